// File: rtl/cacheline_arbiter.sv
// Arbitrates the single burst memory port between icache line fills and dcache fills/write-backs.
// Define CACHELINE_ARB_RR_EN for round-robin; default build is dcache priority with a starvation limit.
module cacheline_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [31:0]  i_address,
   output logic [255:0] i_rdata,
   output logic         i_resp,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [31:0]  d_address,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_rdata,
   output logic         d_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0]   state_q, state_d;
   logic [31:5]  addr_q, addr_d;
   logic         write_q, write_d;
   logic [255:0] wdata_q, wdata_d;
   logic         d_req;
   logic         idle;
   logic         grant_i;
   logic         grant_d;
   logic         unused_addr_bits;

   assign d_req = d_read | d_write;
   assign idle  = (state_q == IDLE);
   assign unused_addr_bits = ^{i_address[4:0], d_address[4:0]};

`ifdef CACHELINE_ARB_RR_EN
   // last_i_q = 1 means the icache was served most recently; reset favours the icache first.
   logic last_i_q, last_i_d;

   assign grant_i = idle & i_read & (~d_req | ~last_i_q);
   assign grant_d = idle & d_req & ~grant_i;

   always_comb begin
      last_i_d = last_i_q;
      if (grant_i)      last_i_d = 1'b1;
      else if (grant_d) last_i_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_i_q <= 1'b0;
      else      last_i_q <= last_i_d;
   end
`else
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign grant_i = idle & i_read & (~d_req | (starve_cnt_q == LIMIT));
   assign grant_d = idle & d_req & ~grant_i;

   // Counts dcache grants that bypassed a waiting icache; saturates at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_i)
         starve_cnt_d = '0;
      else if (grant_d && i_read && (starve_cnt_q != LIMIT))
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) starve_cnt_q <= '0;
      else      starve_cnt_q <= starve_cnt_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d = GRANT_I;
               addr_d  = i_address[31:5];
               write_d = 1'b0;
            end else if (grant_d) begin
               // A simultaneous read+write is illegal; the write takes precedence.
               state_d = GRANT_D;
               addr_d  = d_address[31:5];
               write_d = d_write;
               wdata_d = d_wdata;
            end
         end
         GRANT_I, GRANT_D: begin
            if (pmem_resp) state_d = RELEASE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   // Memory side sees only the captured transaction, never the live requester inputs.
   assign pmem_read    = ((state_q == GRANT_I) | (state_q == GRANT_D)) & ~write_q;
   assign pmem_write   = (state_q == GRANT_D) & write_q;
   assign pmem_address = {addr_q, 5'b0};
   assign pmem_wdata   = wdata_q;

   assign i_resp  = pmem_resp & (state_q == GRANT_I);
   assign d_resp  = pmem_resp & (state_q == GRANT_D);
   assign i_rdata = rst ? pmem_rdata : '0;
   assign d_rdata = rst ? pmem_rdata : '0;

   assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: directed client traffic, a small memory model,
// and a monitor that checks every grant and every client response against queued expectations.
module tb_cacheline_arbiter;

   localparam int MEM_LAT = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_address;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [31:0]  d_address;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   logic         mem_resp = 1'b0;
   logic [255:0] mem_rdata = '0;
   logic         tb_resp = 1'b0;
   logic [255:0] tb_rdata = '0;
   logic         mem_en = 1'b1;

   assign pmem_resp  = mem_resp | tb_resp;
   assign pmem_rdata = mem_resp ? mem_rdata : tb_rdata;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_resp_cyc = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [255:0] wdata;
      logic        chk_gap;
   } grant_t;

   typedef struct {
      logic        is_d;
      logic        chk_data;
      logic [255:0] data;
   } resp_t;

   grant_t gq[$];
   resp_t  rq[$];

   cacheline_arbiter #(.STARVE_LIMIT(2)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory contents: one hand-picked line, otherwise a pattern derived from the address.
   function automatic logic [255:0] line_of(input logic [31:0] a);
      if (a == 32'h6000_0040) return {32{8'hA5}};
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_g(input logic wr, input logic [31:0] a, input logic [255:0] w,
                         input logic gap);
      grant_t g;
      g.wr = wr; g.addr = a; g.wdata = w; g.chk_gap = gap;
      gq.push_back(g);
   endtask

   task automatic push_r(input logic is_d, input logic chk, input logic [255:0] data);
      resp_t r;
      r.is_d = is_d; r.chk_data = chk; r.data = data;
      rq.push_back(r);
   endtask

   // Memory model: answers each strobe after MEM_LAT cycles with a one-cycle pmem_resp.
   initial forever begin
      @(posedge clk); #1;
      if (mem_en && rst && (pmem_read || pmem_write)) begin
         repeat (MEM_LAT - 1) begin
            @(posedge clk); #1;
         end
         mem_rdata = line_of(pmem_address);
         mem_resp  = 1'b1;
         @(posedge clk); #1;
         mem_resp  = 1'b0;
      end
   end

   // Monitor: pops an expected grant on every new strobe and an expected response on every resp.
   initial begin
      logic   prev;
      grant_t g;
      resp_t  r;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 1'b0;
         end else begin
            if ((pmem_read || pmem_write) && !prev) begin
               if (gq.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL grant_unexpected: got addr %h expected no grant", pmem_address);
               end else begin
                  g = gq.pop_front();
                  check("grant_write", 256'(pmem_write), 256'(g.wr));
                  check("grant_read", 256'(pmem_read), 256'(!g.wr));
                  check("grant_addr", 256'(pmem_address), 256'(g.addr));
                  if (g.wr) check("grant_wdata", pmem_wdata, g.wdata);
                  if (g.chk_gap) check("grant_gap_cycles", 256'(cyc - last_resp_cyc), 256'(3));
               end
            end
            if (i_resp || d_resp) begin
               last_resp_cyc = cyc;
               if (rq.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
               end else begin
                  r = rq.pop_front();
                  check("resp_d", 256'(d_resp), 256'(r.is_d));
                  check("resp_i", 256'(i_resp), 256'(!r.is_d));
                  if (r.chk_data) check("resp_data", r.is_d ? d_rdata : i_rdata, r.data);
               end
            end
            prev = pmem_read | pmem_write;
         end
      end
   end

   task automatic run_i(input logic [31:0] a);
      logic got;
      got = 1'b0;
      i_address = a;
      i_read = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         got = i_resp;
      end
      i_read = 1'b0;
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL i_resp_timeout: got no i_resp expected one for addr %h", a);
      end
   endtask

   task automatic run_d(input logic [31:0] base, input logic wr, input logic [255:0] w,
                        input int n);
      logic got;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         d_address = base + 32'(k * 32);
         d_wdata = w;
         d_read = !wr;
         d_write = wr;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = d_resp;
         end
         d_read = 1'b0;
         d_write = 1'b0;
         if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL d_resp_timeout: got no d_resp expected one for addr %h", base);
         end
         if (k < n - 1) @(negedge clk);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_pmem_read"}, 256'(pmem_read), 256'(0));
      check({name, "_pmem_write"}, 256'(pmem_write), 256'(0));
      check({name, "_pmem_address"}, 256'(pmem_address), 256'(0));
      check({name, "_pmem_wdata"}, pmem_wdata, 256'(0));
      check({name, "_resps"}, 256'({i_resp, d_resp}), 256'(0));
      check({name, "_rdata"}, i_rdata | d_rdata, 256'(0));
   endtask

   initial begin
      logic [255:0] w;
      rst = 1'b0;
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      tb_rdata = {64{4'hC}};
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      tb_rdata = '0;
      rst = 1'b1;
      @(negedge clk);
      check("idle_no_strobe", 256'({pmem_read, pmem_write}), 256'(0));

      // Lone icache read: strobe one cycle after the request, low address bits cleared.
      push_g(1'b0, 32'h6000_0040, '0, 1'b0);
      push_r(1'b0, 1'b1, {32{8'hA5}});
      fork
         run_i(32'h6000_0044);
         begin
            @(negedge clk);
            check("lat_pmem_read", 256'(pmem_read), 256'(1));
            check("lat_pmem_address", 256'(pmem_address), 256'(32'h6000_0040));
         end
      join
      repeat (3) @(negedge clk);

      // Simultaneous requests: dcache first, icache after two dead cycles.
      push_g(1'b0, 32'h0000_2000, '0, 1'b0);
      push_g(1'b0, 32'h0000_1220, '0, 1'b1);
      push_r(1'b1, 1'b1, line_of(32'h0000_2000));
      push_r(1'b0, 1'b1, line_of(32'h0000_1220));
      fork
         run_i(32'h0000_1234);
         run_d(32'h0000_2008, 1'b0, '0, 1);
      join
      repeat (3) @(negedge clk);

      // Starvation with limit 2: D, D, I, then the remaining D.
      push_g(1'b0, 32'h0000_0100, '0, 1'b0);
      push_g(1'b0, 32'h0000_0120, '0, 1'b1);
      push_g(1'b0, 32'h3000_0000, '0, 1'b1);
      push_g(1'b0, 32'h0000_0140, '0, 1'b1);
      push_r(1'b1, 1'b1, line_of(32'h0000_0100));
      push_r(1'b1, 1'b1, line_of(32'h0000_0120));
      push_r(1'b0, 1'b1, line_of(32'h3000_0000));
      push_r(1'b1, 1'b1, line_of(32'h0000_0140));
      fork
         run_i(32'h3000_0000);
         run_d(32'h0000_0100, 1'b0, '0, 3);
      join
      repeat (3) @(negedge clk);

      // Write-back: captured data must not follow d_wdata changes mid-burst.
      w = {8{32'h1234_5678}};
      push_g(1'b1, 32'h0000_0080, w, 1'b0);
      push_r(1'b1, 1'b0, '0);
      fork
         run_d(32'h0000_0080, 1'b1, w, 1);
         begin
            @(negedge clk);
            check("wb_pmem_write", 256'(pmem_write), 256'(1));
            @(negedge clk);
            d_wdata = ~w;
            d_address = 32'h0000_0F00;
            @(negedge clk);
            check("wb_wdata_hold", pmem_wdata, w);
            check("wb_addr_hold", 256'(pmem_address), 256'(32'h0000_0080));
         end
      join
      repeat (3) @(negedge clk);

      // Stray pmem_resp while idle produces no client response and no grant.
      tb_rdata = {64{4'h3}};
      tb_resp = 1'b1;
      #1;
      check("idle_resp_ignored", 256'({i_resp, d_resp}), 256'(0));
      @(negedge clk);
      tb_resp = 1'b0;
      tb_rdata = '0;
      check("idle_resp_no_strobe", 256'({pmem_read, pmem_write}), 256'(0));
      @(negedge clk);

      // Reset in the middle of a dcache burst, then a normal icache read.
      mem_en = 1'b0;
      push_g(1'b0, 32'h0000_0500, '0, 1'b0);
      d_address = 32'h0000_0500;
      d_read = 1'b1;
      @(negedge clk);
      check("rst_mid_granted", 256'(pmem_read), 256'(1));
      tb_rdata = {64{4'h9}};
      #2 rst = 1'b0;
      #1 check_all_zero("rst_mid");
      d_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tb_rdata = '0;
      mem_en = 1'b1;
      @(negedge clk);
      push_g(1'b0, 32'h4444_4440, '0, 1'b0);
      push_r(1'b0, 1'b1, line_of(32'h4444_4440));
      run_i(32'h4444_4444);
      repeat (4) @(negedge clk);

      check("grants_left", 256'(gq.size()), 256'(0));
      check("resps_left", 256'(rq.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus expected completion by 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Arbitrates the single burst physical-memory port of the mp4 CPU between the instruction cache and the data cache. Sits between both caches' line-fill/write-back interfaces and the cacheline adaptor driving `pmem_*`. Owns one 256-bit line transaction at a time, holds the winner's request stable, and routes the response back only to the winner.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4. Maximum consecutive dcache grants while an icache request is pending. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  icache line-read request, level, held until `i_resp`.
- `i_address`  in  32  icache line address.
- `i_rdata`  out  256  line data to icache.
- `i_resp`  out  1  icache completion pulse.
- `d_read`  in  1  dcache line-read request, level.
- `d_write`  in  1  dcache line write-back request, level.
- `d_address`  in  32  dcache line address.
- `d_wdata`  in  256  write-back line.
- `d_rdata`  out  256  line data to dcache.
- `d_resp`  out  1  dcache completion pulse.
- `pmem_read`  out  1  line read to memory.
- `pmem_write`  out  1  line write to memory.
- `pmem_address`  out  32  line address; bits [4:0] are always 0.
- `pmem_wdata`  out  256  write-back data.
- `pmem_rdata`  in  256  returned line.
- `pmem_resp`  in  1  one-cycle completion from memory.

## Operation
States:
- `IDLE`: no grant; all `pmem_*` strobes low.
- `GRANT_I`: icache owns memory.
- `GRANT_D`: dcache owns memory.
- `RELEASE`: one dead cycle after completion.

Transitions:
- `IDLE`→`GRANT_D` when a dcache request is present and the icache does not win by starvation.
- `IDLE`→`GRANT_I` when `i_read` is present and either there is no dcache request or `starve_cnt == STARVE_LIMIT`.
- `GRANT_x`→`RELEASE` on `pmem_resp`.
- `RELEASE`→`IDLE` unconditionally.

Grant-time capture:
- At the grant edge, address, direction (read/write) and `d_wdata` are latched into registers.
- `pmem_*` are driven from these registers only, so requester changes mid-transaction are ignored.

Dcache request handling:
- `d_read & d_write` together is illegal; `d_write` wins.
- An assertion fires in simulation when both are high.

Starvation counter:
- `starve_cnt` is $clog2(STARVE_LIMIT+1) bits wide.
- Increments on each dcache grant made while `i_read` is high.
- Clears on every icache grant.
- Saturates at `STARVE_LIMIT`.

Response routing:
- `pmem_rdata` passes combinationally to both `i_rdata` and `d_rdata`.
- `i_resp = pmem_resp & (state==GRANT_I)`.
- `d_resp = pmem_resp & (state==GRANT_D)`.

## Timing
- Reset (asserted low) immediately forces `IDLE`, `starve_cnt=0`, and all outputs to 0.
- Reset mid-transaction abandons the burst; the adaptor is reset by the same `rst`.
- A request seen in `IDLE` at edge N drives the `pmem` strobe from cycle N+1.
- The strobe stays high through the `pmem_resp` cycle and drops the next cycle (`RELEASE`).
- Response latency to a requester equals the memory latency. Arbitration overhead is 1 cycle in, 1 cycle out.
- Minimum back-to-back spacing is 2 cycles between one `pmem_resp` and the next strobe assertion.
- `RELEASE` guarantees the completed client has dropped its request before re-arbitration.
- A request arriving during `GRANT_*` or `RELEASE` waits; it is never dropped.
- `pmem_resp` while in `IDLE` or `RELEASE` is ignored, and no client resp is issued.

## Configuration
- `CACHELINE_ARB_RR_EN` defined: strict round-robin on simultaneous requests. A `last_grant` flop picks the client not served last. `STARVE_LIMIT` and `starve_cnt` are not compiled.
- `CACHELINE_ARB_RR_EN` undefined: dcache priority with the starvation limit described above. This is the default build.

## Test plan
- Lone icache read: `i_read`, `i_address=0x60000044`. Expect `pmem_read=1` and `pmem_address=0x60000040` from the next cycle. On `pmem_resp` with `rdata=0xA5…A5`, expect `i_resp=1` with that data, and `d_resp=0`.
- Simultaneous requests, default build: `i_read` and `d_read` both high. Expect dcache granted first, then icache granted 2 cycles after the dcache `pmem_resp`.
- Starvation, `STARVE_LIMIT=2`: `i_read` held while dcache re-requests continuously. Expect grants D, D, I.
- Write-back: `d_write`, `d_address=0x80`, `d_wdata=0x1234…`. Expect `pmem_write=1` with matching address and data. Changing `d_wdata` mid-burst leaves `pmem_wdata` unchanged.
- Reset mid-burst: drop `rst` during `GRANT_D`. Expect all outputs at 0 immediately. After release, a fresh `i_read` is granted normally.
- With `CACHELINE_ARB_RR_EN`: continuous simultaneous requests give grants alternating I, D, I, D.
